convolution_coprocessor_ctrl: RTL and testbench
===============================================

CONVOLUTION_COPROCESSOR_CTRL -- requirements
Module: convolution_coprocessor_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the unsigned sample width of X and Y.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the X/Y address width; maximum sequence length is 2^ADDR_WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, a one-cycle request to begin a convolution.
REQ-006 SHALL have port size_x, input, ADDR_WIDTH bits, the X length N.
REQ-007 SHALL have port size_y, input, ADDR_WIDTH bits, the Y length M.
REQ-008 SHALL have ports x_addr and y_addr, output, ADDR_WIDTH bits each, the memory read addresses.
REQ-009 SHALL have ports x_data and y_data, input, DATA_WIDTH bits each, the read data, valid exactly 1 cycle after the address.
REQ-010 SHALL have port z_we, output, 1 bit, the Z write strobe.
REQ-011 SHALL have port z_addr, output, ADDR_WIDTH+1 bits, the Z write address.
REQ-012 SHALL have port z_data, output, 2*DATA_WIDTH+ADDR_WIDTH bits, the Z write data.
REQ-013 SHALL have port busy, output, 1 bit, high while a job is in progress.
REQ-014 SHALL have port done, output, 1 bit, a one-cycle pulse when a job completes.

Function
REQ-015 SHALL compute unsigned Z[k] = sum over i of X[i]*Y[k-i] for k = 0..N+M-2, with i from max(0,k-M+1) to min(k,N-1).
REQ-016 SHALL form every product with a single convolution_coprocessor_mult instance (DATA_WIDTH inputs, 2*DATA_WIDTH output); no other multiplier is permitted.
REQ-017 SHALL zero-extend each product into a 2*DATA_WIDTH+ADDR_WIDTH-bit accumulator; overflow is impossible by construction.
REQ-018 SHALL implement the FSM states IDLE, FETCH, DRAIN, WRITE and DONE.
REQ-019 In IDLE, start=1 SHALL latch size_x/size_y, clear k and the accumulator, and go to FETCH; if N=0 or M=0 it SHALL go to DONE instead, with no writes.
REQ-020 In FETCH, the block SHALL drive x_addr=i and y_addr=k-i each cycle, stepping i by 1 so one term issues per cycle.
REQ-021 In FETCH, the block SHALL add the previous cycle's product to the accumulator.
REQ-022 The block SHALL go from FETCH to DRAIN in the cycle after the last term for k issues.
REQ-023 DRAIN SHALL add the final product and go to WRITE.
REQ-024 WRITE SHALL assert z_we for exactly 1 cycle, with z_addr=k and z_data equal to the complete accumulator.
REQ-025 From WRITE, if k<N+M-2 the block SHALL clear the accumulator, increment k and re-enter FETCH; otherwise it SHALL go to DONE.
REQ-026 Cycles per output SHALL be terms(k)+2, and there SHALL be no idle gaps between outputs.
REQ-027 DONE SHALL pulse done=1 for 1 cycle, then go to IDLE.
REQ-028 busy SHALL be 1 in FETCH, DRAIN, WRITE and DONE, and 0 in IDLE.
REQ-029 start SHALL be ignored while busy=1, and a changed size_x/size_y SHALL not affect a running job.
REQ-030 When not in FETCH, x_addr and y_addr SHALL hold 0; z_addr and z_data SHALL hold 0 when z_we=0.

Reset
REQ-031 With rst=1 on a clock edge, the FSM SHALL go to IDLE, and k, i and the accumulator SHALL clear.
REQ-032 While in reset, z_we, busy and done SHALL be 0, and all address and data outputs SHALL be 0.
REQ-033 A reset mid-job SHALL abort it with no further z_we and no done pulse; the next start SHALL run a fresh job.
REQ-034 rst SHALL take priority over start in the same cycle.

Verification
REQ-035 N=1, M=1, X={3}, Y={4}, start at edge 0 -> z_we at cycle 3 with z_addr=0, z_data=12; done at cycle 4; busy high for cycles 1-4.
REQ-036 N=3, M=2, X={1,2,3}, Y={1,1} -> Z={1,3,5,3} written in order at addresses 0..3; busy for 14 cycles before DONE.
REQ-037 N=31, M=31, all samples 255 -> z[30]=2015775 with no wrap, 61 writes, and a single done pulse.
REQ-038 size_x=0, size_y=5, start -> no z_we, and done pulses on the cycle after the start edge.
REQ-039 A start re-pulsed mid-job with new sizes -> ignored, and the original job's output is unchanged.
REQ-040 rst asserted during the FETCH of k=2 (N=3, M=2) -> outputs go to 0 next cycle with no done; a following start yields the full correct Z.

Source files
------------

// File: rtl/convolution_coprocessor_ctrl.sv
// ---------------------------------------------------------------------------
// convolution_coprocessor_ctrl
//
// Sequences a full unsigned linear convolution Z = X * Y out of two
// synchronous-read sample memories into a Z write port. One product term is
// issued per cycle through a single shared multiplier. Each output Z[k]
// takes terms(k)+2 cycles: terms(k) FETCH cycles, one DRAIN cycle and one
// WRITE cycle.
//
// Ports
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   start            one-cycle job request (ignored while busy)
//   size_x, size_y   sequence lengths N and M, latched at start
//   x_addr, y_addr   sample read addresses (0 outside FETCH)
//   x_data, y_data   sample read data, valid one cycle after the address
//   z_we             Z write strobe
//   z_addr, z_data   Z write address / data (0 when z_we is low)
//   busy             high while a job is in progress
//   done             one-cycle pulse at job completion
//
// This file also holds convolution_coprocessor_mult, the only multiplier.
// ---------------------------------------------------------------------------

module convolution_coprocessor_mult #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] p
);
  assign p = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
endmodule

// state  | meaning
// IDLE   | waiting for start
// FETCH  | issuing one (i, k-i) address pair per cycle for output k
// DRAIN  | last product of output k arrives and is accumulated
// WRITE  | Z[k] written; advance to k+1 or finish
// DONE   | one-cycle done pulse
module convolution_coprocessor_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            size_x,
  input  logic [ADDR_WIDTH-1:0]            size_y,
  output logic [ADDR_WIDTH-1:0]            x_addr,
  output logic [ADDR_WIDTH-1:0]            y_addr,
  input  logic [DATA_WIDTH-1:0]            x_data,
  input  logic [DATA_WIDTH-1:0]            y_data,
  output logic                             z_we,
  output logic [ADDR_WIDTH:0]              z_addr,
  output logic [2*DATA_WIDTH+ADDR_WIDTH-1:0] z_data,
  output logic                             busy,
  output logic                             done
);
  localparam int AW  = ADDR_WIDTH;
  localparam int KW  = ADDR_WIDTH + 1;
  localparam int ACW = 2*DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic [AW-1:0]           n_q, m_q, i_q;
  logic [KW-1:0]           k_q;
  logic [ACW-1:0]          acc_q;
  logic                    pv_q;   // a product from last cycle's FETCH is on the data bus
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACW-1:0]          prod_ext;
  logic [AW-1:0]           i_hi;
  logic                    k_last;

  // lowest i contributing to output kv: max(0, kv-M+1)
  function automatic logic [AW-1:0] lo_of(input logic [KW-1:0] kv, input logic [AW-1:0] m);
    if (kv >= {1'b0, m}) lo_of = AW'(kv - {1'b0, m} + KW'(1));
    else                 lo_of = '0;
  endfunction

  convolution_coprocessor_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .a (x_data),
    .b (y_data),
    .p (prod)
  );

  assign prod_ext = {{AW{1'b0}}, prod};
  // highest i contributing to output k: min(k, N-1)
  assign i_hi     = (k_q < {1'b0, n_q}) ? AW'(k_q) : n_q - AW'(1);
  // k == N+M-2, evaluated with headroom so N+M cannot wrap
  assign k_last   = ({1'b0, k_q} + (AW+2)'(2)) >= ({2'b0, n_q} + {2'b0, m_q});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    x_addr    = '0;
    y_addr    = '0;
    z_we      = 1'b0;
    z_addr    = '0;
    z_data    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (size_x == '0 || size_y == '0) state_nxt = DONE;
          else                               state_nxt = FETCH;
        end
      end
      FETCH: begin
        busy   = 1'b1;
        x_addr = i_q;
        y_addr = AW'(k_q - {1'b0, i_q});
        if (i_q == i_hi) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        z_we      = 1'b1;
        z_addr    = k_q;
        z_data    = acc_q;
        state_nxt = k_last ? DONE : FETCH;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q   <= '0;
      m_q   <= '0;
      k_q   <= '0;
      i_q   <= '0;
      acc_q <= '0;
      pv_q  <= 1'b0;
    end else begin
      pv_q <= (state == FETCH);
      case (state)
        IDLE: begin
          if (start) begin
            n_q   <= size_x;
            m_q   <= size_y;
            k_q   <= '0;
            i_q   <= '0;
            acc_q <= '0;
          end
        end
        FETCH: begin
          // first FETCH cycle of an output has no product in flight yet
          if (pv_q) acc_q <= acc_q + prod_ext;
          if (i_q != i_hi) i_q <= i_q + AW'(1);
        end
        DRAIN: acc_q <= acc_q + prod_ext;
        WRITE: begin
          if (!k_last) begin
            k_q   <= k_q + KW'(1);
            i_q   <= lo_of(k_q + KW'(1), m_q);
            acc_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_convolution_coprocessor_ctrl.sv
module tb_convolution_coprocessor_ctrl;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int ZW = 2*DW + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] size_x = '0, size_y = '0;
  logic [AW-1:0] x_addr, y_addr;
  logic [DW-1:0] x_data = '0, y_data = '0;
  logic          z_we;
  logic [AW:0]   z_addr;
  logic [ZW-1:0] z_data;
  logic          busy, done;

  convolution_coprocessor_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .size_x(size_x), .size_y(size_y),
    .x_addr(x_addr), .y_addr(y_addr), .x_data(x_data), .y_data(y_data),
    .z_we(z_we), .z_addr(z_addr), .z_data(z_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] xmem [32];
  logic [DW-1:0] ymem [32];

  always @(posedge clk) begin
    x_data <= xmem[x_addr];
    y_data <= ymem[y_addr];
  end

  typedef struct packed {
    logic [AW-1:0] xa;
    logic [AW-1:0] ya;
    logic          we;
    logic [AW:0]   za;
    logic [ZW-1:0] zd;
    logic          bz;
    logic          dn;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   cur_busy = 1'b0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   we_cyc = 0, done_cyc = 0;
  int   wr_cnt = 0, done_cnt = 0, busy_cnt = 0;
  logic [ZW-1:0] obs_z [64];

  // Z[k] straight from the definition: every (i, k-i) pair inside both ranges
  function automatic logic [ZW-1:0] conv_ref(int n, int m, int k);
    longint s = 0;
    for (int i = 0; i < n; i++)
      if (k - i >= 0 && k - i < m) s += longint'(xmem[i]) * longint'(ymem[k-i]);
    return ZW'(s);
  endfunction

  // expected per-cycle outputs of one job, from the cycle after the start edge
  task automatic build(int n, int m);
    exp_t e;
    if (n != 0 && m != 0) begin
      for (int k = 0; k <= n + m - 2; k++) begin
        for (int i = 0; i < n; i++) begin
          if (k - i >= 0 && k - i < m) begin
            e = '0; e.bz = 1'b1; e.xa = AW'(i); e.ya = AW'(k - i);
            q.push_back(e);
          end
        end
        e = '0; e.bz = 1'b1;
        q.push_back(e);
        e = '0; e.bz = 1'b1; e.we = 1'b1; e.za = (AW+1)'(k); e.zd = conv_ref(n, m, k);
        q.push_back(e);
      end
    end
    e = '0; e.bz = 1'b1; e.dn = 1'b1;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) q.delete();
    else if (start && !cur_busy) begin
      start_cyc = cyc;
      build(int'(size_x), int'(size_y));
    end
  end

  always @(negedge clk) begin
    exp_t e, g;
    if (q.size() > 0) e = q.pop_front();
    else              e = '0;
    cur_busy = e.bz;
    g.xa = x_addr; g.ya = y_addr; g.we = z_we; g.za = z_addr;
    g.zd = z_data; g.bz = busy;   g.dn = done;
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL outputs cyc=%0d got %h exp %h", cyc, g, e);
    end
    if (z_we) begin
      obs_z[z_addr] = z_data;
      wr_cnt++;
      we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  task automatic chk(string nm, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic clr_obs();
    wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 64; i++) obs_z[i] = '1;
  endtask

  task automatic do_start(int n, int m);
    @(posedge clk); #1;
    size_x = AW'(n); size_y = AW'(m); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget, string nm);
    int c = 0;
    while ((cur_busy || q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) chk({nm, "_timeout"}, c, 0);
    @(posedge clk); #1;
  endtask

  task automatic load_321();
    for (int i = 0; i < 32; i++) begin xmem[i] = '0; ymem[i] = '0; end
    xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
    ymem[0] = 1; ymem[1] = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin xmem[i] = '0; ymem[i] = '0; end
    clr_obs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_zwe", z_we, 0);

    // single-term job: 3*4
    xmem[0] = 3; ymem[0] = 4;
    clr_obs();
    do_start(1, 1);
    wait_idle(50, "n1m1");
    chk("n1m1_z0", obs_z[0], 12);
    chk("n1m1_we_cycle", we_cyc - start_cyc + 1, 3);
    chk("n1m1_done_cycle", done_cyc - start_cyc + 1, 4);
    chk("n1m1_busy_cycles", busy_cnt, 4);

    // N=3, M=2
    load_321();
    clr_obs();
    do_start(3, 2);
    wait_idle(100, "n3m2");
    chk("n3m2_z0", obs_z[0], 1);
    chk("n3m2_z1", obs_z[1], 3);
    chk("n3m2_z2", obs_z[2], 5);
    chk("n3m2_z3", obs_z[3], 3);
    chk("n3m2_writes", wr_cnt, 4);
    chk("n3m2_busy_cycles", busy_cnt, 15);

    // maximum length, all 255
    for (int i = 0; i < 32; i++) begin xmem[i] = 8'hff; ymem[i] = 8'hff; end
    clr_obs();
    do_start(31, 31);
    wait_idle(3000, "n31m31");
    chk("n31_z30", obs_z[30], 2015775);
    chk("n31_z0", obs_z[0], 65025);
    chk("n31_z60", obs_z[60], 65025);
    chk("n31_writes", wr_cnt, 61);
    chk("n31_done_pulses", done_cnt, 1);

    // empty X
    clr_obs();
    do_start(0, 5);
    wait_idle(20, "n0");
    chk("n0_writes", wr_cnt, 0);
    chk("n0_done_pulses", done_cnt, 1);
    chk("n0_done_cycle", done_cyc - start_cyc + 1, 1);

    // start re-pulsed mid-job with other sizes
    load_321();
    clr_obs();
    do_start(3, 2);
    repeat (4) @(posedge clk);
    #1 size_x = 7; size_y = 7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(100, "restart");
    chk("restart_z1", obs_z[1], 3);
    chk("restart_z3", obs_z[3], 3);
    chk("restart_writes", wr_cnt, 4);
    chk("restart_done_pulses", done_cnt, 1);

    // reset during FETCH of k=2 (cycle 8 of the job)
    clr_obs();
    do_start(3, 2);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_writes", wr_cnt, 2);
    chk("abort_done_pulses", done_cnt, 0);
    chk("abort_busy", busy, 0);

    clr_obs();
    do_start(3, 2);
    wait_idle(100, "after_abort");
    chk("after_abort_z2", obs_z[2], 5);
    chk("after_abort_writes", wr_cnt, 4);

    // reset and start together: reset wins
    clr_obs();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; size_x = 3; size_y = 2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_start_busy_cycles", busy_cnt, 0);
    chk("rst_start_writes", wr_cnt, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
